adder_share_ctrl: RTL

//   Arbiter and sequencer that shares one 8-bit ripple-carry adder (fulladder_8bit) between two requesters.

---
 rtl/adder_share_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//   Shares one 8-bit ripple-carry adder between two requesters. Each request is
//   an 8-bit or 16-bit add or subtract. A 16-bit operation takes two passes
//   through the adder, and the carry is held in a register between the passes.
//   Results leave on a single response channel that is tagged with the
//   requester id.
//
//   Parameters
//     RR_EN       1 = round-robin between requesters, 0 = requester 0 always wins
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     reqN_valid/ready      request handshake for requester N (N = 0, 1)
//     reqN_a, reqN_b        16-bit operands (only [7:0] used for 8-bit ops)
//     reqN_sub              1 = A - B, 0 = A + B
//     reqN_wide             1 = 16-bit operation, 0 = 8-bit
//     rsp_valid/ready       response handshake
//     rsp_id                requester that owns the result
//     rsp_sum, rsp_cout     result and final carry (for sub: 1 = no borrow)
//     busy                  sequencer is not idle

// Plain 8-bit ripple-carry adder, the shared resource.
module fulladder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    // The carry ripples through a local variable so that the carry chain is a
    // simple sequence of assignments rather than a self-referencing vector.
    always_comb begin
        logic carry;
        carry = cin;
        s     = '0;
        for (int i = 0; i < 8; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module adder_share_ctrl #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_sub,
    input  logic        req0_wide,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_sub,
    input  logic        req1_wide,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_cout,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      state;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_sub;
    logic        op_wide;
    logic        op_id;
    logic        carry_reg;
    logic        last_grant;
    logic [15:0] res_sum;
    logic        res_cout;

    logic        grant_id;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic        sel_sub;
    logic        sel_wide;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_s;
    logic        add_cout;

    // Arbitration: a lone requester wins outright; on a tie, round-robin
    // favours whoever was not granted last, fixed priority favours req0.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = RR_EN ? ~last_grant : 1'b0;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !reset && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && !reset && req1_valid &&  grant_id;
    assign busy       = (state != IDLE);

    assign sel_a    = grant_id ? req1_a    : req0_a;
    assign sel_b    = grant_id ? req1_b    : req0_b;
    assign sel_sub  = grant_id ? req1_sub  : req0_sub;
    assign sel_wide = grant_id ? req1_wide : req0_wide;

    // The adder sees the low bytes plus the sub carry-in during LO and the
    // high bytes plus the saved inter-pass carry during HI.
    always_comb begin
        add_a   = op_a[7:0];
        add_b   = op_b[7:0];
        add_cin = op_sub;
        if (state == HI) begin
            add_a   = op_a[15:8];
            add_b   = op_b[15:8];
            add_cin = carry_reg;
        end
    end

    fulladder_8bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    // Sequencer. B is stored already inverted for subtraction so both passes
    // are plain additions. The rsp_* outputs are loaded only on the first RESP
    // cycle, so they keep the last result after it has been accepted while the
    // internal result registers are reused by the next operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_wide    <= 1'b0;
            op_id      <= 1'b0;
            carry_reg  <= 1'b0;
            last_grant <= 1'b1;
            res_sum    <= '0;
            res_cout   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b ^ {16{sel_sub}};
                        op_sub     <= sel_sub;
                        op_wide    <= sel_wide;
                        op_id      <= grant_id;
                        last_grant <= grant_id;
                        state      <= LO;
                    end
                end
                LO: begin
                    res_sum[7:0] <= add_s;
                    carry_reg    <= add_cout;
                    if (op_wide) begin
                        state <= HI;
                    end else begin
                        res_sum[15:8] <= 8'h00;
                        res_cout      <= add_cout;
                        state         <= RESP;
                    end
                end
                HI: begin
                    res_sum[15:8] <= add_s;
                    res_cout      <= add_cout;
                    state         <= RESP;
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= op_id;
                        rsp_sum   <= res_sum;
                        rsp_cout  <= res_cout;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
